jtcop_obj_linebuf: RTL and testbench



---
 rtl/jtcop_obj_linebuf.sv | 123 ++++++++++++
 tb/tb_jtcop_obj_linebuf.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/jtcop_obj_linebuf.sv
// rtl/jtcop_obj_linebuf.sv - double object line buffer with first-drawn-wins writes and erase-on-scan
module jtcop_obj_linebuf #(
   parameter int AW = 9,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pxl_cen,
   input  logic          LHBL,
   input  logic [AW-1:0] hdump,
   input  logic          buf_we,
   input  logic [AW-1:0] buf_addr,
   input  logic [DW-1:0] buf_data,
   output logic          buf_busy,
   output logic          line,
   output logic [DW-1:0] obj_pxl
);

   typedef enum logic [1:0] {IDLE, RD, WR, CLEAR} state_t;

   state_t        state, next_state;
   logic [AW-1:0] cnt;
   logic [AW-1:0] addr_l;
   logic [DW-1:0] data_l;
   logic          bank_l;
   logic [3:0]    rd_col;
   logic          accept;
   logic          do_wr;
   logic          lhbl_l;
   logic          erase_pend;
   logic          scan_bank;
   logic [AW-1:0] scan_addr;
   logic [DW-1:0] scan_cap;

   logic [DW-1:0] mem0 [0:2**AW-1];
   logic [DW-1:0] mem1 [0:2**AW-1];

   assign buf_busy = (state != IDLE);
   // A pixel only lands if the location still holds a transparent colour
   assign do_wr    = (state == WR) && (rd_col == 4'd0) && !rst;

   // Next-state logic; transparent requests are swallowed without leaving IDLE
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (buf_we && buf_data[3:0] != 4'd0) begin
               accept     = 1'b1;
               next_state = RD;
            end
         end
         RD:      next_state = WR;
         WR:      next_state = IDLE;
         CLEAR:   if (cnt == '1) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State register and clear counter; reset always restarts the full clear
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= next_state;
         if (state == CLEAR) cnt <= cnt + 1'b1;
      end
   end

   // Request latch and read-back of the target location's colour
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_l <= buf_addr;
         data_l <= buf_data;
         bank_l <= line;
      end
      if (state == RD) rd_col <= bank_l ? mem1[addr_l][3:0] : mem0[addr_l][3:0];
   end

   // Bank swap on the falling edge of LHBL, regardless of pixel enable or FSM state
   always_ff @(posedge clk) begin
      if (rst) begin
         line   <= 1'b0;
         lhbl_l <= 1'b0;
      end else begin
         lhbl_l <= LHBL;
         if (lhbl_l && !LHBL) line <= ~line;
      end
   end

   // Scan-out: read the idle bank, remember where for the erase, emit the previous column
   always_ff @(posedge clk) begin
      if (rst) begin
         erase_pend <= 1'b0;
         scan_cap   <= '0;
         obj_pxl    <= '0;
      end else begin
         erase_pend <= pxl_cen;
         if (pxl_cen) begin
            scan_addr <= hdump;
            scan_bank <= ~line;
            scan_cap  <= line ? mem0[hdump] : mem1[hdump];
            obj_pxl   <= (LHBL && state != CLEAR) ? scan_cap : '0;
         end
      end
   end

   // Bank 0 writes: clear sweep, erase behind the scan, renderer pixel
   always_ff @(posedge clk) begin
      if (state == CLEAR && !rst) mem0[cnt] <= '0;
      if (erase_pend && !scan_bank) mem0[scan_addr] <= '0;
      if (do_wr && !bank_l) mem0[addr_l] <= data_l;
   end

   // Bank 1 writes: clear sweep, erase behind the scan, renderer pixel
   always_ff @(posedge clk) begin
      if (state == CLEAR && !rst) mem1[cnt] <= '0;
      if (erase_pend && scan_bank) mem1[scan_addr] <= '0;
      if (do_wr && bank_l) mem1[addr_l] <= data_l;
   end

endmodule

// File: tb/tb_jtcop_obj_linebuf.sv
// tb/tb_jtcop_obj_linebuf.sv - directed self-checking bench for jtcop_obj_linebuf
module tb_jtcop_obj_linebuf;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pxl_cen = 1'b0;
   logic       LHBL = 1'b1;
   logic [8:0] hdump = '0;
   logic       buf_we = 1'b0;
   logic [8:0] buf_addr = '0;
   logic [7:0] buf_data = '0;
   logic       buf_busy;
   logic       line;
   logic [7:0] obj_pxl;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_line [512];
   logic [9:0] busy_pat;

   jtcop_obj_linebuf #(.AW(9), .DW(8)) dut (
      .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .hdump(hdump),
      .buf_we(buf_we), .buf_addr(buf_addr), .buf_data(buf_data),
      .buf_busy(buf_busy), .line(line), .obj_pxl(obj_pxl)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (buf_busy !== 1'b0 && n < 1000) begin
         tick();
         n++;
      end
      check(tag, buf_busy, 0);
   endtask

   task automatic wr(input logic [8:0] a, input logic [7:0] d);
      wait_idle("wr_idle");
      buf_we = 1'b1; buf_addr = a; buf_data = d;
      tick();
      buf_we = 1'b0;
      tick();
      tick();
   endtask

   task automatic swap();
      LHBL = 1'b0;
      tick();
      LHBL = 1'b1;
      tick();
   endtask

   task automatic sweep(input logic lv, input int div);
      LHBL = lv;
      for (int h = 0; h <= 512; h++) begin
         hdump = 9'(h % 512);
         pxl_cen = 1'b1;
         tick();
         pxl_cen = 1'b0;
         if (h >= 1) check($sformatf("scan col %0d", h - 1), obj_pxl, lv ? exp_line[h - 1] : 8'h00);
         for (int d = 1; d < div; d++) tick();
      end
      for (int i = 0; i < 512; i++) exp_line[i] = 8'h00;
   endtask

   initial begin
      int n;
      for (int i = 0; i < 512; i++) exp_line[i] = 8'h00;

      // Reset and full clear
      tick();
      check("rst busy", buf_busy, 1);
      check("rst line", line, 0);
      check("rst obj_pxl", obj_pxl, 0);
      rst = 1'b0;
      n = 0;
      while (buf_busy === 1'b1 && n < 600) begin
         tick();
         n++;
      end
      check("clear cycles", n, 512);
      check("clear obj_pxl", obj_pxl, 0);

      // Basic write, swap, scan, then confirm erase
      wr(9'd20, 8'h5A);
      swap();
      check("swap1 line", line, 1);
      exp_line[20] = 8'h5A;
      sweep(1'b1, 1);
      sweep(1'b1, 1);

      // First-drawn wins; transparent does not block
      wr(9'd100, 8'h13);
      wr(9'd100, 8'h27);
      wr(9'd101, 8'h30);
      wr(9'd101, 8'h41);
      swap();
      check("swap2 line", line, 0);
      exp_line[100] = 8'h13;
      exp_line[101] = 8'h41;
      sweep(1'b1, 2);

      // Back-to-back handshake with buf_we held high
      wait_idle("hs_idle");
      busy_pat = 10'b0110110110;
      buf_we = 1'b1; buf_addr = 9'd200; buf_data = 8'h61;
      for (int i = 0; i < 10; i++) begin
         check($sformatf("busy cycle %0d", i), buf_busy, busy_pat[9 - i]);
         tick();
         if (i == 0) begin buf_addr = 9'd201; buf_data = 8'h62; end
         if (i == 3) begin buf_addr = 9'd202; buf_data = 8'h63; end
         if (i == 6) buf_we = 1'b0;
      end
      swap();
      check("swap3 line", line, 1);
      exp_line[200] = 8'h61;
      exp_line[201] = 8'h62;
      exp_line[202] = 8'h63;
      sweep(1'b1, 1);

      // Swap while the request sits in RD: pixel goes to the bank captured at acceptance
      wait_idle("mid_idle");
      buf_we = 1'b1; buf_addr = 9'd300; buf_data = 8'h7C;
      tick();
      buf_we = 1'b0;
      LHBL = 1'b0;
      check("mid line before", line, 1);
      tick();
      check("mid line after", line, 0);
      LHBL = 1'b1;
      tick();
      tick();
      exp_line[300] = 8'h7C;
      sweep(1'b1, 1);

      // Blanked scan still erases
      wr(9'd50, 8'h88);
      LHBL = 1'b0;
      tick();
      check("blank line", line, 1);
      sweep(1'b0, 1);
      LHBL = 1'b1;
      tick();
      sweep(1'b1, 1);

      // Reset while a write is in WR
      wait_idle("rstwr_idle");
      buf_we = 1'b1; buf_addr = 9'd60; buf_data = 8'h99;
      tick();
      buf_we = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst2 busy", buf_busy, 1);
      check("rst2 line", line, 0);
      check("rst2 obj_pxl", obj_pxl, 0);
      wait_idle("rst2 clear");
      sweep(1'b1, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
